// File: rtl/dot_product_accumulator.sv
// Registered operand stage feeding a combinational 4x4 array multiplier, accumulating
// LEN products per vector and presenting the sum on a valid/ready output port.

module array_multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);
    always_comb begin
        product = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[i]) begin
                product = product + ({4'b0000, a} << i);
            end
        end
    end
endmodule

module dot_product_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 10,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic [3:0]       a_q, b_q;
    logic             p_valid;
    logic [7:0]       product;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf_q;
    logic [ACC_W:0]   sum_ext;
    logic             accept, last_term, release_result;

    array_multiplier u_mult (
        .a       (a_q),
        .b       (b_q),
        .product (product)
    );

    assign accept         = in_valid && in_ready;
    assign last_term      = (cnt == CNT_W'(LEN - 1));
    assign release_result = out_valid && out_ready;
    assign sum_ext        = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, product};

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = last_term ? DRAIN : ACCUM;
                end
            end
            DRAIN: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_valid <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_next;
            p_valid <= accept;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
                cnt <= cnt + CNT_W'(1);
            end else if (release_result) begin
                cnt <= '0;
            end
            // p_valid is never set in DONE, so release and add cannot collide
            if (release_result) begin
                acc   <= '0;
                ovf_q <= 1'b0;
            end else if (p_valid) begin
                acc   <= sum_ext[ACC_W-1:0];
                ovf_q <= ovf_q | sum_ext[ACC_W];
            end
        end
    end

    assign out_sum = acc;
    assign out_ovf = ovf_q;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench: three instances (LEN=4, LEN=8, LEN=1) checked against a
// per-vector arithmetic model of the dot product, directed plus randomized vectors.

module tb_dot_product_accumulator;
    localparam int NI = 3;

    logic       clk;
    logic       rst_n;
    logic       in_valid  [NI];
    logic       in_ready  [NI];
    logic [3:0] in_a      [NI];
    logic [3:0] in_b      [NI];
    logic       out_valid [NI];
    logic       out_ready [NI];
    logic [9:0] out_sum   [NI];
    logic       out_ovf   [NI];

    int n_tests = 0;
    int n_fail  = 0;
    int pa [8];
    int pb [8];

    dot_product_accumulator #(.LEN(4), .ACC_W(10)) u_len4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_ovf(out_ovf[0])
    );
    dot_product_accumulator #(.LEN(8), .ACC_W(10)) u_len8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_ovf(out_ovf[1])
    );
    dot_product_accumulator #(.LEN(1), .ACC_W(10)) u_len1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(out_sum[2]), .out_ovf(out_ovf[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int k, input string tag);
        check({tag, "_in_ready"}, longint'(in_ready[k]), 1);
        check({tag, "_out_valid"}, longint'(out_valid[k]), 0);
        check({tag, "_out_sum"}, longint'(out_sum[k]), 0);
        check({tag, "_out_ovf"}, longint'(out_ovf[k]), 0);
    endtask

    // Offer one pair and return just after the edge that accepted it.
    task automatic send_pair(input int k, input int a, input int b);
        bit rdy;
        int waited = 0;
        in_valid[k] = 1'b1;
        in_a[k]     = 4'(a);
        in_b[k]     = 4'(b);
        forever begin
            rdy = in_ready[k];
            tick();
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
    endtask

    // Sends n pairs from pa/pb, idling 'gap' cycles between terms, then holds
    // out_ready low for 'hold' extra DONE cycles before consuming the result.
    task automatic do_vector(input int k, input int n, input int gap, input int hold);
        int total = 0;
        int exp_sum, exp_ovf;
        for (int i = 0; i < n; i++) begin
            send_pair(k, pa[i], pb[i]);
            total += pa[i] * pb[i];
            if (i < n - 1 && gap > 0) begin
                in_valid[k] = 1'b0;
                repeat (gap) begin
                    in_a[k] = 4'($urandom_range(15));
                    in_b[k] = 4'($urandom_range(15));
                    tick();
                end
            end
        end
        exp_sum = total % 1024;
        exp_ovf = (total >= 1024) ? 1 : 0;
        check("drain_in_ready", longint'(in_ready[k]), 0);
        check("early_out_valid", longint'(out_valid[k]), 0);
        in_valid[k]  = 1'b0;
        out_ready[k] = (hold == 0);
        tick();
        check("done_out_valid", longint'(out_valid[k]), 1);
        check("done_out_sum", longint'(out_sum[k]), exp_sum);
        check("done_out_ovf", longint'(out_ovf[k]), exp_ovf);
        check("done_in_ready", longint'(in_ready[k]), 0);
        if (hold > 0) begin
            repeat (hold) begin
                in_valid[k] = 1'b1;
                in_a[k]     = 4'($urandom_range(15));
                in_b[k]     = 4'($urandom_range(15));
                tick();
                check("hold_out_valid", longint'(out_valid[k]), 1);
                check("hold_out_sum", longint'(out_sum[k]), exp_sum);
                check("hold_out_ovf", longint'(out_ovf[k]), exp_ovf);
                check("hold_in_ready", longint'(in_ready[k]), 0);
            end
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        tick();
        check_idle(k, "after_handshake");
        out_ready[k] = 1'b0;
    endtask

    task automatic set_pairs(input int a0, input int b0, input int a1, input int b1,
                             input int a2, input int b2, input int a3, input int b3);
        pa[0] = a0; pb[0] = b0; pa[1] = a1; pb[1] = b1;
        pa[2] = a2; pb[2] = b2; pa[3] = a3; pb[3] = b3;
    endtask

    initial begin
        int pulses, last_pulse, expected_sum;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            in_a[k]      = '0;
            in_b[k]      = '0;
            out_ready[k] = 1'b0;
        end
        rst_n = 1'b0;
        #3;
        for (int k = 0; k < NI; k++) check_idle(k, "reset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < NI; k++) check_idle(k, "idle_hold");

        // Reset pulse while idle
        #2 rst_n = 1'b0;
        #1 check_idle(0, "idle_reset");
        #2 rst_n = 1'b1;
        tick();

        // Back-to-back vector, out_ready high
        set_pairs(3, 5, 15, 15, 0, 9, 7, 2);
        do_vector(0, 4, 0, 0);

        // Gapped vector with delayed consumption
        set_pairs(1, 2, 2, 3, 3, 4, 4, 5);
        do_vector(0, 4, 3, 5);

        // Overflow on LEN=8, then a clean vector
        for (int i = 0; i < 8; i++) begin pa[i] = 15; pb[i] = 15; end
        do_vector(1, 8, 0, 2);
        for (int i = 0; i < 8; i++) begin pa[i] = (i < 4) ? 1 : 0; pb[i] = pa[i]; end
        do_vector(1, 8, 0, 0);

        // Reset mid-vector after two accepted terms
        send_pair(0, 9, 9);
        send_pair(0, 8, 8);
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1 check_idle(0, "mid_reset");
        #2 rst_n = 1'b1;
        tick();
        check_idle(0, "post_reset");
        set_pairs(1, 1, 1, 1, 1, 1, 1, 1);
        do_vector(0, 4, 0, 0);

        // LEN=1 streaming: one result every three cycles
        in_valid[2]  = 1'b1;
        in_a[2]      = 4'd6;
        in_b[2]      = 4'd7;
        out_ready[2] = 1'b1;
        pulses       = 0;
        last_pulse   = -1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid[2]) begin
                check("len1_sum", longint'(out_sum[2]), 42);
                if (last_pulse >= 0) check("len1_period", longint'(c - last_pulse), 3);
                last_pulse = c;
                pulses++;
            end
        end
        check("len1_pulses", longint'(pulses), 4);
        in_valid[2] = 1'b0;
        repeat (4) tick();
        out_ready[2] = 1'b0;
        check_idle(2, "len1_end");

        // Randomized vectors against the arithmetic model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 8; i++) begin
                pa[i] = $urandom_range(15);
                pb[i] = $urandom_range(15);
            end
            do_vector(r % 2, (r % 2 == 0) ? 4 : 8, $urandom_range(2), $urandom_range(3));
        end
        for (int r = 0; r < 4; r++) begin
            pa[0] = $urandom_range(15);
            pb[0] = $urandom_range(15);
            expected_sum = pa[0] * pb[0];
            do_vector(2, 1, 0, $urandom_range(2));
            check("len1_model", longint'(out_sum[2]), 0);
            if (expected_sum < 0) check("len1_neg", 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Sequential stage that sits directly downstream of the combinational 4x4 unsigned array multiplier, `array_multiplier`. It registers 4-bit operand pairs through a valid/ready handshake and feeds them to an internal `array_multiplier` instance. It accumulates LEN consecutive 8-bit products into one dot-product result. The result is presented on a valid/ready output port and held until it is consumed.

## Interface
- `LEN`, default 4: number of terms per dot product; legal range is LEN ≥ 1.
- `ACC_W`, default 10: accumulator and result width; legal range is ACC_W ≥ 8.
- `CNT_W`, default `$clog2(LEN+1)`: width of the term counter.
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `in_valid`  input  1: an operand pair is offered.
- `in_ready`  output  1: the block accepts the operand pair in this cycle.
- `in_a`  input  4: unsigned multiplicand.
- `in_b`  input  4: unsigned multiplier.
- `out_valid`  output  1: `out_sum` and `out_ovf` hold a completed result.
- `out_ready`  input  1: the downstream stage consumes the result.
- `out_sum`  output  ACC_W: dot-product sum, modulo 2^ACC_W.
- `out_ovf`  output  1: sticky flag, set if any add in this vector carried out of ACC_W bits.

## Operation
- An operand pair is accepted when `in_valid` and `in_ready` are both high at a rising edge.
  - Accepted operands are loaded into registers `a_q` and `b_q`, and the internal flag `p_valid` is set.
  - The instanced multiplier computes the product combinationally from `a_q` and `b_q`.
- On an edge where `p_valid` is 1, the accumulator updates: `acc <= acc + zero_extend(product)`.
  - The add is ACC_W bits wide and wraps.
  - The carry out is ORed into `ovf_q`.
- On an edge with no accept, `p_valid` clears. An idle `in_valid` leaves `acc` and the count unchanged, so gaps inside a vector are allowed.
- FSM states:
  - IDLE: `cnt` = 0, `acc` = 0, `ovf_q` = 0, `in_ready` = 1.
  - ACCUM: 1 ≤ `cnt` < LEN, `in_ready` = 1.
  - DRAIN: `cnt` = LEN, the last product is pending its add, `in_ready` = 0.
  - DONE: `out_valid` = 1, `in_ready` = 0.
- FSM transitions:
  - IDLE→ACCUM on accept.
  - IDLE or ACCUM→DRAIN on the accept that makes `cnt` = LEN. For LEN = 1, the first accept in IDLE goes directly to DRAIN.
  - DRAIN→DONE unconditionally on the next edge.
  - DONE→IDLE on `out_valid` && `out_ready`. This edge clears `acc`, `ovf_q` and `cnt`.
- `in_ready` is decoded from the registered state only. It never depends combinationally on `in_valid` or `out_ready`.
- `out_sum` = `acc` and `out_ovf` = `ovf_q` at all times. Both are stable throughout DONE while `out_ready` is low.
- `in_valid`, `in_a` and `in_b` are ignored while `in_ready` = 0.
- Reset mid-operation: the partial vector is discarded and the FSM returns to IDLE. No output pulse occurs.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n` low):
  - State = IDLE, `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0.
  - `a_q` = 0, `b_q` = 0, `p_valid` = 0, `cnt` = 0.
- Latency: if the last term is accepted at edge T, `out_valid` is 1 after edge T+1.
- Output handshake at edge H: `out_valid` = 0 and `in_ready` = 1 after H. The earliest accept of the next vector is at edge H+1.
- Peak throughput: LEN+2 cycles per result when inputs stream with no gaps and `out_ready` is held high.
- No combinational path exists from input ports to output ports.

## Test plan
- Reset, or reset pulsed while idle → `in_ready` = 1, `out_valid` = 0, `out_sum` = 0 and `out_ovf` = 0 immediately. These values hold with `in_valid` = 0.
- LEN=4, ACC_W=10, back-to-back pairs (3,5), (15,15), (0,9), (7,2), `out_ready` = 1:
  - `out_sum` = 254 and `out_ovf` = 0.
  - `out_valid` is high one edge after the last accept, for exactly one cycle.
- LEN=4 with `in_valid` deasserted for 3 cycles between terms, pairs (1,2), (2,3), (3,4), (4,5), `out_ready` = 0 for 5 cycles:
  - `out_sum` = 40 stays stable.
  - `in_ready` = 0, and pairs offered during DONE are not counted.
  - After the handshake, `out_valid` and the accumulator both read 0.
- LEN=8, ACC_W=10, eight pairs (15,15):
  - `out_sum` = 776 (1800 mod 1024) and `out_ovf` = 1.
  - The next vector of four (1,1) pairs followed by four (0,0) pairs → `out_sum` = 4, `out_ovf` = 0.
- LEN=4, `rst_n` pulsed low after 2 accepted terms, then (1,1)×4 → `out_sum` = 4. No earlier `out_valid` pulse occurs.
- LEN=1, `in_valid` and `out_ready` held at 1, `in_a` = 6, `in_b` = 7 → `out_sum` = 42. `out_valid` pulses every 3 cycles.
